// File: rtl/dct2d_stream_if.sv
// ---------------------------------------------------------------------------
// dct2d_stream_if
// Row-streaming handshake bundle for the 8x8 2-D DCT block.
//   in_valid/in_ready/in_data     : one row of 8 signed IN_W samples in
//   out_valid/out_ready/out_data  : one row of 8 signed OUT_W coefficients out
//   out_last                      : marks output row 7
// Modports: master = row producer / coefficient consumer, slave = DCT block.
// ---------------------------------------------------------------------------
interface dct2d_stream_if #(
    parameter int IN_W  = 9,
    parameter int OUT_W = IN_W + 18
);
    logic                 in_valid;
    logic                 in_ready;
    logic [8*IN_W-1:0]    in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*OUT_W-1:0]   out_data;
    logic                 out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/dct2d_stream.sv
// ---------------------------------------------------------------------------
// dct2d_stream
// 8x8 two-dimensional integer DCT over a row stream: row pass on each input
// row into a transpose buffer, an 8-cycle column pass into an output buffer,
// then the coefficient rows are streamed out.
//
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset
//   bus     : dct2d_stream_if.slave (input rows / output coefficient rows)
//   busy_o  : high in every state except IDLE
//
// Build option: DCT2D_SAT_EN defined -> final narrowing saturates to OUT_W,
// otherwise it wraps (keeps the low OUT_W bits).
//
// State | meaning
// IDLE  | waiting for input row 0
// ROW   | accepting rows 1..7, row pass into transpose buffer
// COL   | 8 cycles of column pass, one transpose row per cycle
// OUT   | presenting output rows 0..7
// ---------------------------------------------------------------------------
module dct2d_stream #(
    parameter int IN_W  = 9,
    parameter int OUT_W = IN_W + 18
) (
    input  logic            clk_i,
    input  logic            rst_i,
    dct2d_stream_if.slave   bus,
    output logic            busy_o
);
    localparam int RW = IN_W + 9;   // width after row pass
    localparam int CW = IN_W + 18;  // width after column pass

    // 8-point 1-D integer DCT basis: DC row of ones gives the exact sum,
    // every AC row sums to zero so constant input yields zero AC terms.
    localparam int CM [8][8] = '{
        '{  1,   1,   1,   1,   1,   1,   1,   1},
        '{ 12,  10,   6,   3,  -3,  -6, -10, -12},
        '{  8,   4,  -4,  -8,  -8,  -4,   4,   8},
        '{ 10,  -3, -12,  -6,   6,  12,   3, -10},
        '{  8,  -8,  -8,   8,   8,  -8,  -8,   8},
        '{  6, -12,   3,  10, -10,  -3,  12,  -6},
        '{  4,  -8,   8,  -4,  -4,   8,  -8,   4},
        '{  3,  -6,  10, -12,  12, -10,   6,  -3}
    };

    typedef enum logic [1:0] {S_IDLE, S_ROW, S_COL, S_OUT} state_t;

    state_t      state_q, state_d;
    logic [2:0]  row_cnt_q, row_cnt_d;
    logic [2:0]  col_cnt_q, col_cnt_d;
    logic [2:0]  out_cnt_q, out_cnt_d;

    logic        row_we;
    logic        col_we;
    logic        in_ready;
    logic        out_valid;
    logic        out_last;

    logic signed [IN_W-1:0]  in_s    [8];
    logic signed [RW-1:0]    row_res [8];
    logic signed [CW-1:0]    col_res [8];
    logic signed [RW-1:0]    tbuf_q  [8][8];
    logic signed [OUT_W-1:0] obuf_q  [8][8];
    logic [8*OUT_W-1:0]      out_data;

    function automatic logic signed [63:0] coef(input int k, input int n);
        return 64'(CM[k][n]);
    endfunction

    function automatic logic signed [OUT_W-1:0] narrow(input logic signed [CW-1:0] x);
`ifdef DCT2D_SAT_EN
        localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
        localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (OUT_W - 1));
        logic signed [63:0] xl;
        xl = 64'(x);
        if (xl > SAT_MAX)
            return OUT_W'(SAT_MAX);
        else if (xl < SAT_MIN)
            return OUT_W'(SAT_MIN);
        else
            return OUT_W'(xl);
`else
        return OUT_W'(x);
`endif
    endfunction

    // Row pass on the incoming row (combinational, captured on transfer).
    always_comb begin
        for (int n = 0; n < 8; n++) begin
            in_s[n] = bus.in_data[n*IN_W +: IN_W];
        end
        for (int k = 0; k < 8; k++) begin
            row_res[k] = '0;
            for (int n = 0; n < 8; n++) begin
                row_res[k] = row_res[k] + RW'(64'(in_s[n]) * coef(k, n));
            end
        end
    end

    // Column pass on transpose-buffer row col_cnt_q.
    always_comb begin
        for (int m = 0; m < 8; m++) begin
            col_res[m] = '0;
            for (int r = 0; r < 8; r++) begin
                col_res[m] = col_res[m] + CW'(64'(tbuf_q[col_cnt_q][r]) * coef(m, r));
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        out_cnt_d = out_cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy_o    = 1'b1;
        row_we    = 1'b0;
        col_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy_o   = 1'b0;
                if (bus.in_valid) begin
                    row_we    = 1'b1;
                    row_cnt_d = 3'd1;
                    state_d   = S_ROW;
                end
            end
            S_ROW: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    row_we    = 1'b1;
                    row_cnt_d = row_cnt_q + 3'd1;
                    if (row_cnt_q == 3'd7) begin
                        state_d = S_COL;
                    end
                end
            end
            S_COL: begin
                col_we    = 1'b1;
                col_cnt_d = col_cnt_q + 3'd1;
                if (col_cnt_q == 3'd7) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_last  = (out_cnt_q == 3'd7);
                if (bus.out_ready) begin
                    out_cnt_d = out_cnt_q + 3'd1;
                    if (out_cnt_q == 3'd7) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            row_cnt_q <= '0;
            col_cnt_q <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            col_cnt_q <= col_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // Input row r lands in column r, so COL cycle c reads row c = frequency c.
    always_ff @(posedge clk_i) begin
        if (row_we && !rst_i) begin
            for (int k = 0; k < 8; k++) begin
                tbuf_q[k][row_cnt_q] <= row_res[k];
            end
        end
    end

    // Column pass of horizontal frequency c fills column c of the output
    // buffer, so output row i carries vertical frequency i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) begin
                for (int v = 0; v < 8; v++) begin
                    obuf_q[i][v] <= '0;
                end
            end
        end else if (col_we) begin
            for (int m = 0; m < 8; m++) begin
                obuf_q[m][col_cnt_q] <= narrow(col_res[m]);
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int v = 0; v < 8; v++) begin
            out_data[v*OUT_W +: OUT_W] = obuf_q[out_cnt_q][v];
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_data  = out_data;

endmodule

// File: tb/tb_dct2d_stream.sv
module tb_dct2d_stream;
    localparam int IN_W = 9;
    localparam int OW   = IN_W + 18;
    localparam int OW14 = 14;

    localparam int CM [8][8] = '{
        '{  1,   1,   1,   1,   1,   1,   1,   1},
        '{ 12,  10,   6,   3,  -3,  -6, -10, -12},
        '{  8,   4,  -4,  -8,  -8,  -4,   4,   8},
        '{ 10,  -3, -12,  -6,   6,  12,   3, -10},
        '{  8,  -8,  -8,   8,   8,  -8,  -8,   8},
        '{  6, -12,   3,  10, -10,  -3,  12,  -6},
        '{  4,  -8,   8,  -4,  -4,   8,  -8,   4},
        '{  3,  -6,  10, -12,  12, -10,   6,  -3}
    };

    logic clk = 1'b0;
    logic rst;
    logic busy, busy14;
    always #5 clk = ~clk;

    dct2d_stream_if #(.IN_W(IN_W), .OUT_W(OW))   bus ();
    dct2d_stream_if #(.IN_W(IN_W), .OUT_W(OW14)) bus14 ();

    assign bus14.in_valid  = bus.in_valid;
    assign bus14.in_data   = bus.in_data;
    assign bus14.out_ready = bus.out_ready;

    dct2d_stream #(.IN_W(IN_W), .OUT_W(OW)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus), .busy_o(busy));
    dct2d_stream #(.IN_W(IN_W), .OUT_W(OW14)) dut14 (
        .clk_i(clk), .rst_i(rst), .bus(bus14), .busy_o(busy14));

    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model state
    int     nrows = 0;
    bit     pending = 0;
    longint t7 = 0;
    int     oidx = 0;
    bit     started = 0;
    bit     just_reset = 0;
    bit     prev_hold = 0;
    logic [8*OW-1:0] prev_data;
    longint xin [8][8];
    longint ey  [8][8];
    longint cap [8][8];
    longint cap14 [8][8];

    // stimulus state
    longint drv [8][8];
    int     or_mode = 0;
    int     hold = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint narrow(input longint y, input int w);
        longint lim;
        lim = longint'(1) <<< (w - 1);
`ifdef DCT2D_SAT_EN
        if (y > lim - 1) return lim - 1;
        if (y < -lim) return -lim;
        return y;
`else
        return (y <<< (64 - w)) >>> (64 - w);
`endif
    endfunction

    function automatic longint fld(input logic [8*OW-1:0] d, input int v);
        logic signed [OW-1:0] f;
        f = d[v*OW +: OW];
        return longint'(f);
    endfunction

    function automatic longint fld14(input logic [8*OW14-1:0] d, input int v);
        logic signed [OW14-1:0] f;
        f = d[v*OW14 +: OW14];
        return longint'(f);
    endfunction

    // Y = C * X * C^T, computed directly
    task automatic compute_block();
        for (int u = 0; u < 8; u++)
            for (int v = 0; v < 8; v++) begin
                longint s;
                s = 0;
                for (int r = 0; r < 8; r++)
                    for (int n = 0; n < 8; n++)
                        s += longint'(CM[u][r]) * longint'(CM[v][n]) * xin[r][n];
                ey[u][v] = s;
            end
    endtask

    always @(negedge clk) begin
        bit eov, erdy, ebusy;
        erdy  = !pending;
        ebusy = pending || (nrows > 0);
        eov   = pending && (cyc - t7 >= 9);
        if (started) begin
            check("busy", busy, ebusy);
            check("busy14", busy14, ebusy);
            check("in_ready", bus.in_ready, erdy);
            check("in_ready14", bus14.in_ready, erdy);
            check("out_valid", bus.out_valid, eov);
            check("out_valid14", bus14.out_valid, eov);
            if (just_reset) begin
                check("reset_out_data", longint'(|bus.out_data), 0);
                check("reset_out_last", bus.out_last, 0);
            end
            if (eov) begin
                check("out_last", bus.out_last, oidx == 7);
                check("out_last14", bus14.out_last, oidx == 7);
                for (int v = 0; v < 8; v++) begin
                    check($sformatf("coef[%0d][%0d]", oidx, v),
                          fld(bus.out_data, v), narrow(ey[oidx][v], OW));
                    check($sformatf("coef14[%0d][%0d]", oidx, v),
                          fld14(bus14.out_data, v), narrow(ey[oidx][v], OW14));
                end
                if (prev_hold) check("out_data_stable", longint'(bus.out_data == prev_data), 1);
            end
        end
        prev_hold = started && !rst && eov && !bus.out_ready;
        prev_data = bus.out_data;
        if (rst) begin
            nrows = 0; pending = 0; oidx = 0;
            started = 1; just_reset = 1;
        end else begin
            just_reset = 0;
            if (started) begin
                if (bus.in_valid && erdy) begin
                    for (int n = 0; n < 8; n++) begin
                        logic signed [IN_W-1:0] s;
                        s = bus.in_data[n*IN_W +: IN_W];
                        xin[nrows][n] = longint'(s);
                    end
                    nrows++;
                    if (nrows == 8) begin
                        compute_block();
                        pending = 1; t7 = cyc; nrows = 0; oidx = 0;
                    end
                end
                if (eov && bus.out_ready) begin
                    for (int v = 0; v < 8; v++) begin
                        cap[oidx][v]   = fld(bus.out_data, v);
                        cap14[oidx][v] = fld14(bus14.out_data, v);
                    end
                    oidx++;
                    if (oidx == 8) begin
                        pending = 0; oidx = 0;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (or_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (pending && oidx == 4 && hold < 5) begin
                    bus.out_ready = 1'b0;
                    hold++;
                end else begin
                    bus.out_ready = 1'b1;
                end
            end
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_row(input int r);
        logic [8*IN_W-1:0] d;
        int n;
        for (int j = 0; j < 8; j++) begin
            logic [63:0] t;
            t = drv[r][j];
            d[j*IN_W +: IN_W] = t[IN_W-1:0];
        end
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check("in_ready_timeout", 0, 1);
        step();
    endtask

    task automatic send_block(input int gap_row, input int gap_len, input bit junk);
        for (int r = 0; r < 8; r++) begin
            if (r == gap_row) begin
                bus.in_valid = 1'b0;
                repeat (gap_len) step();
            end
            put_row(r);
        end
        if (junk) begin
            bus.in_valid = 1'b1;
            bus.in_data  = {$urandom, $urandom, $urandom};
            repeat (4) step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((pending || nrows != 0) && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) check("block_done_timeout", 0, 1);
        repeat (2) step();
    endtask

    task automatic fill_const(input longint val);
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++)
                drv[r][j] = val;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++)
                drv[r][j] = longint'($urandom_range(0, 511)) - 256;
    endtask

    task automatic check_dc(input string nm, input longint dc);
        int nz;
        nz = 0;
        for (int u = 0; u < 8; u++)
            for (int v = 0; v < 8; v++)
                if ((u != 0 || v != 0) && cap[u][v] != 0) nz++;
        check({nm, "_dc"}, cap[0][0], dc);
        check({nm, "_ac_nonzero"}, nz, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);

        // all ones, continuous
        or_mode = 0;
        fill_const(1);
        send_block(8, 0, 0);
        wait_idle();
        check_dc("ones", 64);

        // all -256
        fill_const(-256);
        send_block(8, 0, 1);
        wait_idle();
        check_dc("neg256", -16384);

        // ones with a 3-cycle gap before row 3
        fill_const(1);
        send_block(3, 3, 0);
        wait_idle();
        check_dc("ones_gap", 64);

        // impulse at x[0][0] pins the basis orientation
        fill_const(0);
        drv[0][0] = 1;
        send_block(8, 0, 0);
        wait_idle();
        check("impulse_00", cap[0][0], 1);
        check("impulse_01", cap[0][1], 12);
        check("impulse_11", cap[1][1], 144);
        check("impulse_77", cap[7][7], 9);

        // consumer holds row 4 for 5 cycles
        or_mode = 2;
        hold = 0;
        fill_rand();
        send_block(8, 0, 1);
        wait_idle();
        check("hold_cycles", hold, 5);
        or_mode = 0;

        // narrowing on the 14-bit instance
        fill_const(255);
        send_block(8, 0, 0);
        wait_idle();
        check("c255_full", cap[0][0], 16320);
`ifdef DCT2D_SAT_EN
        check("c255_ow14", cap14[0][0], 8191);
`else
        check("c255_ow14", cap14[0][0], -64);
`endif

        // reset after row 5, then a clean block of 2
        fill_rand();
        for (int r = 0; r < 6; r++) put_row(r);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_in_ready", bus.in_ready, 1);
        fill_const(2);
        send_block(8, 0, 0);
        wait_idle();
        check_dc("after_abort", 128);

        // randomized blocks with gaps, junk during COL/OUT, random out_ready
        or_mode = 1;
        for (int b = 0; b < 20; b++) begin
            fill_rand();
            if (b == 3) fill_const(-256);
            if (b == 4) fill_const(255);
            send_block($urandom_range(0, 8), $urandom_range(1, 3), $urandom_range(0, 1) == 1);
            wait_idle();
        end
        or_mode = 0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dct2d_stream.md
DCT2D_STREAM -- requirements
Module: dct2d_stream

Interface
REQ-001 Parameter IN_W, default 9: signed input sample width in bits, legal range 4..16.
REQ-002 Parameter OUT_W, default IN_W+18: signed output coefficient width in bits, legal range 8..IN_W+18.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_data holds a valid row of samples.
REQ-006 in_ready  output  1  block can accept a row this cycle.
REQ-007 in_data  input  8*IN_W  one row of 8 signed samples; sample j is at bits [j*IN_W +: IN_W].
REQ-008 out_valid  output  1  out_data holds a valid coefficient row.
REQ-009 out_ready  input  1  consumer accepts the row this cycle.
REQ-010 out_data  output  8*OUT_W  one row of 8 signed coefficients; coefficient v is at bits [v*OUT_W +: OUT_W].
REQ-011 out_last  output  1  high with out_valid on output row 7 only.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The block SHALL compute the 8x8 two-dimensional DCT of one block as a row transform, a transpose, then a column transform, using the team's 8-point 1-D DCT core for both passes.
REQ-014 Each 1-D pass SHALL produce a DC term equal to the exact sum of its 8 inputs and AC terms of zero for constant input; internal widths SHALL be IN_W+9 after the row pass and IN_W+18 after the column pass, with no internal loss.
REQ-015 State machine states: IDLE, ROW, COL, OUT.
REQ-016 IDLE and ROW: in_ready=1; a row transfers when in_valid && in_ready; the row pass result of input row r is written to column r of the transpose buffer.
REQ-017 Input gaps (in_valid low) in ROW SHALL stall without corrupting the row count.
REQ-018 IDLE->ROW on the first transfer; ROW->COL on the transfer of row 7.
REQ-019 COL: in_ready=0; lasts exactly 8 cycles; cycle c passes transpose-buffer row c through the column pass into the output buffer; COL->OUT after cycle 7.
REQ-020 OUT: out_valid=1, out_data = output row i (coefficients Y[i][0..7]), starting at i=0; i advances on out_valid && out_ready; out_data stays stable while out_ready=0.
REQ-021 OUT->IDLE on the transfer of row 7, which carries out_last=1.
REQ-022 Latency: first out_valid SHALL be asserted exactly 9 cycles after the cycle in which input row 7 transfers.
REQ-023 in_valid while in_ready=0 SHALL be ignored; no input is buffered during COL or OUT.
REQ-024 Final narrowing from IN_W+18 to OUT_W bits follows REQ-031/REQ-032; when OUT_W = IN_W+18 the values pass unchanged.

Reset
REQ-025 While reset is high at a clock edge: state=IDLE, row and column counters=0, out_valid=0, out_last=0, busy=0, in_ready=1 after the edge.
REQ-026 out_data SHALL reset to all zeros; transpose-buffer contents are don't-care.
REQ-027 Reset asserted in any state SHALL abort the block in progress; the next transfer after reset is treated as row 0.
REQ-028 Reset has priority over every handshake in the same cycle.

Configuration
REQ-029 Macro DCT2D_SAT_EN selects the narrowing mode.
REQ-030 The macro SHALL affect only the final narrowing step.
REQ-031 With DCT2D_SAT_EN defined: each coefficient saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-032 Without DCT2D_SAT_EN: each coefficient is truncated to its low OUT_W bits (two's-complement wrap).

Verification
REQ-033 Defaults; 8 rows of all samples = 1, in_valid continuous, out_ready=1 -> row 0 coefficient 0 = 64, all 63 others = 0, out_last on row 7, first out_valid 9 cycles after row 7 transfers.
REQ-034 Defaults; all samples = -256 -> coefficient (0,0) = -16384, all others 0.
REQ-035 Defaults; in_valid low for 3 cycles between rows 2 and 3 -> results identical to REQ-033; first out_valid 9 cycles after row 7 transfers.
REQ-036 out_ready held 0 for 5 cycles during row 4 -> out_data constant during the hold, row 5 follows only after the transfer, in_ready=0 throughout OUT.
REQ-037 IN_W=9, OUT_W=14, all samples = 255 -> coefficient (0,0) = 8191 with DCT2D_SAT_EN, -64 without.
REQ-038 Reset pulsed after input row 5, then a full block of samples = 2 -> busy=0 after reset, output coefficient (0,0) = 128, no residue from the aborted block.
